// File: rtl/control_cronometro_if.sv
// control_cronometro_if
//   Groups the stopwatch controller's user-side and display-side signals.
//   master: drives the two debounced buttons and reads the display/status signals.
//   slave : the controller; samples the buttons and drives the display/status signals.
//   btn_start_stop, btn_lap_reset : debounced button levels, asynchronous to clk
//   minutos_bin/segundos_bin/centesimas_bin : displayed M:SS:tt in binary
//   estado : FSM state, desborde : sticky overflow, tick_cent : hundredth pulse
interface control_cronometro_if;
    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic [3:0] minutos_bin;
    logic [5:0] segundos_bin;
    logic [6:0] centesimas_bin;
    logic [1:0] estado;
    logic       desborde;
    logic       tick_cent;

    modport master (
        output btn_start_stop, btn_lap_reset,
        input  minutos_bin, segundos_bin, centesimas_bin, estado, desborde, tick_cent
    );

    modport slave (
        input  btn_start_stop, btn_lap_reset,
        output minutos_bin, segundos_bin, centesimas_bin, estado, desborde, tick_cent
    );
endinterface

// File: rtl/control_cronometro.sv
// control_cronometro
//   Stopwatch sequencing controller. Turns two button levels into RUN/PAUSE/LAP/CLEAR
//   actions, divides clk into 1/100 s ticks, keeps the M:SS:tt counters and drives the
//   display with either live time or a frozen lap snapshot.
//   clk : system clock          rst : asynchronous reset, active-high
//   bus : control_cronometro_if.slave (buttons in, display and status out)
//
//   state      | meaning
//   CERO       | cleared, waiting for start
//   CORRIENDO  | counting, live time shown
//   PAUSA      | counters frozen (also entered on overflow)
//   VUELTA     | counting, lap snapshot shown
module control_cronometro #(
    parameter int DIV_CENT = 250000,
    parameter int MAX_MIN  = 9
) (
    input  logic clk,
    input  logic rst,
    control_cronometro_if.slave bus
);
    localparam int PW = (DIV_CENT > 1) ? $clog2(DIV_CENT) : 1;

    typedef enum logic [1:0] {
        CERO      = 2'b00,
        CORRIENDO = 2'b01,
        PAUSA     = 2'b10,
        VUELTA    = 2'b11
    } state_t;

    state_t state, state_nx;

    // [0] and [1] form the synchroniser, [2] is the edge register.
    logic [2:0] ss_sync, lr_sync;
    logic pss, plr;

    logic [PW-1:0] presc;
    logic [3:0] min_q, lap_min;
    logic [5:0] seg_q, lap_seg;
    logic [6:0] cent_q, lap_cent;
    logic desborde_q;

    logic counting, tick, at_max, ovf;
    logic cap_lap, clr_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync <= '0;
            lr_sync <= '0;
        end else begin
            ss_sync <= {ss_sync[1:0], bus.btn_start_stop};
            lr_sync <= {lr_sync[1:0], bus.btn_lap_reset};
        end
    end

    // A simultaneous start_stop press wins; the lap_reset press is dropped.
    assign pss = ss_sync[1] & ~ss_sync[2];
    assign plr = lr_sync[1] & ~lr_sync[2] & ~pss;

    assign counting = (state == CORRIENDO) || (state == VUELTA);
    assign tick     = counting && (presc == PW'(DIV_CENT - 1));
    assign at_max   = (min_q == 4'(MAX_MIN)) && (seg_q == 6'd59) && (cent_q == 7'd99);
    assign ovf      = tick && at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CERO;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cap_lap  = 1'b0;
        clr_all  = 1'b0;
        case (state)
            CERO: begin
                if (pss) state_nx = CORRIENDO;
            end
            CORRIENDO: begin
                if (ovf || pss) begin
                    state_nx = PAUSA;
                end else if (plr) begin
                    state_nx = VUELTA;
                    cap_lap  = 1'b1;
                end
            end
            VUELTA: begin
                if (ovf || pss) state_nx = PAUSA;
                else if (plr)   state_nx = CORRIENDO;
            end
            PAUSA: begin
                if (pss && !desborde_q) begin
                    state_nx = CORRIENDO;
                end else if (plr) begin
                    state_nx = CERO;
                    clr_all  = 1'b1;
                end
            end
            default: state_nx = CERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            min_q      <= '0;
            seg_q      <= '0;
            cent_q     <= '0;
            lap_min    <= '0;
            lap_seg    <= '0;
            lap_cent   <= '0;
            desborde_q <= 1'b0;
        end else if (clr_all) begin
            presc      <= '0;
            min_q      <= '0;
            seg_q      <= '0;
            cent_q     <= '0;
            lap_min    <= '0;
            lap_seg    <= '0;
            lap_cent   <= '0;
            desborde_q <= 1'b0;
        end else begin
            // Prescaler only moves while counting, so PAUSA keeps the fraction.
            if (counting) presc <= tick ? '0 : presc + PW'(1);

            // At MAX_MIN:59:99 the tick leaves the counters saturated.
            if (tick && !at_max) begin
                if (cent_q == 7'd99) begin
                    cent_q <= '0;
                    if (seg_q == 6'd59) begin
                        seg_q <= '0;
                        min_q <= min_q + 4'd1;
                    end else begin
                        seg_q <= seg_q + 6'd1;
                    end
                end else begin
                    cent_q <= cent_q + 7'd1;
                end
            end

            if (ovf) desborde_q <= 1'b1;

            if (cap_lap) begin
                lap_min  <= min_q;
                lap_seg  <= seg_q;
                lap_cent <= cent_q;
            end
        end
    end

    assign bus.minutos_bin    = (state == VUELTA) ? lap_min  : min_q;
    assign bus.segundos_bin   = (state == VUELTA) ? lap_seg  : seg_q;
    assign bus.centesimas_bin = (state == VUELTA) ? lap_cent : cent_q;
    assign bus.estado         = state;
    assign bus.desborde       = desborde_q;
    assign bus.tick_cent      = tick;
endmodule

// File: tb/tb_control_cronometro.sv
// tb_control_cronometro
//   Directed bench for control_cronometro. dut1 uses DIV_CENT=4, MAX_MIN=9 for the
//   run/lap/pause/reset scenarios; dut2 uses DIV_CENT=2, MAX_MIN=1 so saturation at
//   the last minute is reachable in a short run. Expected displays are pushed to a
//   queue before the stimulus that should produce them and popped when sampled.
module tb_control_cronometro;
    logic clk = 1'b0;
    logic rst = 1'b1;

    control_cronometro_if bus1();
    control_cronometro_if bus2();

    control_cronometro #(.DIV_CENT(4), .MAX_MIN(9)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    control_cronometro #(.DIV_CENT(2), .MAX_MIN(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         unit;
        logic [3:0] m;
        logic [5:0] s;
        logic [6:0] c;
        logic [1:0] e;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic ss1, input logic lr1, input logic ss2, input logic lr2);
        bus1.btn_start_stop = ss1;
        bus1.btn_lap_reset  = lr1;
        bus2.btn_start_stop = ss2;
        bus2.btn_lap_reset  = lr2;
    endtask

    // Action lands on the 3rd edge; 3 more idle edges re-arm the edge detector.
    task automatic press(input logic ss1, input logic lr1, input logic ss2, input logic lr2);
        set_btn(ss1, lr1, ss2, lr2);
        cyc(3);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3);
    endtask

    task automatic expect_out(input string tag, input int unit, input int m, input int s,
                              input int c, input int e, input int d);
        exp_t x;
        x.tag = tag;
        x.unit = unit;
        x.m = 4'(m);
        x.s = 6'(s);
        x.c = 7'(c);
        x.e = 2'(e);
        x.d = 1'(d);
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        logic [19:0] obs, want;
        x = sb.pop_front();
        if (x.unit == 1)
            obs = {bus1.minutos_bin, bus1.segundos_bin, bus1.centesimas_bin, bus1.estado, bus1.desborde};
        else
            obs = {bus2.minutos_bin, bus2.segundos_bin, bus2.centesimas_bin, bus2.estado, bus2.desborde};
        want = {x.m, x.s, x.c, x.e, x.d};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: got %0d:%0d:%0d estado=%b desborde=%b, expected %0d:%0d:%0d estado=%b desborde=%b",
                   x.tag, obs[19:16], obs[15:10], obs[9:3], obs[2:1], obs[0],
                   x.m, x.s, x.c, x.e, x.d);
        end
    endtask

    task automatic check_tick(input string tag, input logic want);
        checks++;
        assert (bus1.tick_cent === want) else begin
            errors++;
            $error("FAIL %s: tick_cent got %b expected %b", tag, bus1.tick_cent, want);
        end
    endtask

    initial begin
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state before any clock edge.
        expect_out("reset_dut1", 1, 0, 0, 0, 0, 0);
        expect_out("reset_dut2", 2, 0, 0, 0, 0, 0);
        #2;
        check_out();
        check_out();
        check_tick("reset_tick", 1'b0);
        cyc(3);
        rst = 1'b0;

        // 1: async reset in the middle of a count.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("run_0_12_34", 1, 0, 12, 34, 1, 0);
        cyc(4933);
        check_out();
        expect_out("async_rst", 1, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 check_out();
        #1 rst = 1'b0;
        cyc(1);

        // 2: tick spacing and carries.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_tick("tick_first", 1'b1);
        cyc(1);
        check_tick("tick_gap", 1'b0);
        expect_out("cent_after_tick", 1, 0, 0, 1, 1, 0);
        check_out();
        cyc(3);
        check_tick("tick_second", 1'b1);
        expect_out("run_0_00_99", 1, 0, 0, 99, 1, 0);
        cyc(389);
        check_out();
        expect_out("carry_seg", 1, 0, 1, 0, 1, 0);
        cyc(4);
        check_out();
        expect_out("run_0_59_99", 1, 0, 59, 99, 1, 0);
        cyc(23596);
        check_out();
        expect_out("carry_min", 1, 1, 0, 0, 1, 0);
        cyc(4);
        check_out();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("clear_after_run", 1, 0, 0, 0, 0, 0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_out();

        // 3: lap snapshot while counting continues.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(95);
        expect_out("lap_capture", 1, 0, 0, 25, 3, 0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_out();
        expect_out("lap_hold", 1, 0, 0, 25, 3, 0);
        cyc(100);
        check_out();
        cyc(93);
        expect_out("lap_release_live", 1, 0, 0, 75, 1, 0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_out();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);

        // 4: pause keeps the prescaler fraction; lap in pause clears.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(196);
        expect_out("pause_0_00_50", 1, 0, 0, 50, 2, 0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_out();
        expect_out("pause_hold", 1, 0, 0, 50, 2, 0);
        cyc(100);
        check_out();
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(3);
        expect_out("resume_no_tick_yet", 1, 0, 0, 50, 1, 0);
        check_out();
        check_tick("resume_tick_wait", 1'b0);
        cyc(1);
        check_tick("resume_tick_remaining", 1'b1);
        cyc(1);
        expect_out("resume_advance", 1, 0, 0, 51, 1, 0);
        check_out();
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("pause_lap_clears", 1, 0, 0, 0, 0, 0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_out();

        // 6: simultaneous presses and held buttons.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(34);
        expect_out("both_pss_wins", 1, 0, 0, 10, 2, 0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_out();
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(3);
        expect_out("held_start", 1, 0, 2, 60, 1, 0);
        cyc(1000);
        check_out();
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(3);
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(3);
        expect_out("held_lap_capture", 1, 0, 2, 61, 3, 0);
        check_out();
        expect_out("held_lap_hold", 1, 0, 2, 61, 3, 0);
        cyc(1000);
        check_out();
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("held_lap_release", 1, 0, 2, 61, 3, 0);
        cyc(10);
        check_out();

        // 5: saturation at the last minute (dut2).
        press(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("near_max", 2, 1, 59, 98, 1, 0);
        cyc(23993);
        check_out();
        expect_out("at_max", 2, 1, 59, 99, 1, 0);
        cyc(2);
        check_out();
        expect_out("overflow", 2, 1, 59, 99, 2, 1);
        cyc(2);
        check_out();
        expect_out("overflow_hold", 2, 1, 59, 99, 2, 1);
        cyc(20);
        check_out();
        expect_out("overflow_start_ignored", 2, 1, 59, 99, 2, 1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_out();
        expect_out("overflow_clear", 2, 0, 0, 0, 0, 0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_out();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
